cap_data_memory: RTL and testbench

- Successor to the 129-bit word-only data memory.
- Capability-width data memory for the CHERI-RISC-V core. It is parametrised on capability width and depth.
- Adds byte/half/word accesses, multi-beat capability accesses, a per-granule tag array with tag-clearing semantics, error reporting, and a valid/ready request handshake.
- Sits behind the MEM stage and serves both scalar loads/stores and capability loads/stores (CLC/CSC).

---
 rtl/cap_mem_pkg.sv | 14 +
 rtl/cap_tag_ram.sv | 19 +
 rtl/cap_data_memory.sv | 104 ++++++++++
 tb/tb_cap_data_memory.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cap_mem_pkg.sv
// cap_mem_pkg: size encodings, FSM state and geometry helpers for the capability data memory
package cap_mem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_CAP = 2'b11;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  function automatic int cap_words(input int cap_w);
    return cap_w / 32;
  endfunction
  function automatic logic [31:0] align_mask(input logic [1:0] sz, input int cap_w);
    return sz == SZ_B ? 32'd0 : sz == SZ_H ? 32'd1 : sz == SZ_W ? 32'd3 : 32'(cap_w / 8 - 1);
  endfunction
endpackage

// File: rtl/cap_tag_ram.sv
// cap_tag_ram: one tag flop per capability granule, asynchronously cleared
module cap_tag_ram #(
  parameter int N = 64,
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  logic          i_wval,
  input  logic [IW-1:0] i_ridx,
  output logic          o_rtag
);
  logic [N-1:0] r_tags;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_tags <= '0;
    else if (i_we) r_tags[i_widx] <= i_wval;
  assign o_rtag = r_tags[i_ridx];
endmodule

// File: rtl/cap_data_memory.sv
// cap_data_memory: tagged capability-width data memory with scalar and multi-beat capability accesses
module cap_data_memory import cap_mem_pkg::*; #(
  parameter int DEPTH_WORDS = 256,
  parameter int CAP_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [CAP_W:0]   req_wdata,
  output logic             rsp_valid,
  output logic [CAP_W:0]   rsp_rdata,
  output logic             rsp_err
);
  localparam int CAP_WORDS = cap_words(CAP_W);
  localparam int CL = $clog2(CAP_WORDS);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int DW = CAP_W + 1;
  localparam int ACC_W = CAP_W - 32;
  state_t r_state;
  logic [CL-1:0] r_beat;
  logic [AW-1:0] r_idx;
  logic r_we;
  logic [CAP_W:0] r_wdata;
  logic [ACC_W-1:0] r_acc;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic w_busy, w_acc, w_err, w_go, w_beat_v, w_cap, w_we, w_final, w_tag;
  logic [31:0] w_last, w_rword, w_cap_word, w_sdata, w_wword, w_lval;
  logic [CL-1:0] w_k;
  logic [AW-1:0] w_idx;
  logic [CAP_W:0] w_wd, w_rsp;
  logic [1:0] w_off;
  logic [3:0] w_be;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  assign req_ready = r_state == ST_IDLE && !rst;
  assign w_busy = r_state == ST_BUSY;
  assign w_acc = req_valid && req_ready;
  assign w_last = {2'b00, req_addr[31:2]} + (req_size == SZ_CAP ? 32'(CAP_WORDS - 1) : 32'd0);
  assign w_err = w_acc && ((req_addr & align_mask(req_size, CAP_W)) != 32'd0 || w_last >= 32'(DEPTH_WORDS));
  assign w_go = w_acc && !w_err;
  assign w_beat_v = w_go || w_busy;
  assign w_cap = w_busy || req_size == SZ_CAP;
  assign w_k = w_busy ? r_beat : '0;
  assign w_idx = (w_busy ? r_idx : req_addr[AW+1:2]) + AW'(w_k);
  assign w_we = w_busy ? r_we : req_we;
  assign w_wd = w_busy ? r_wdata : req_wdata;
  assign w_final = w_cap && w_k == CL'(CAP_WORDS - 1);
  assign w_off = req_addr[1:0];
  assign w_cap_word = 32'(w_wd[CAP_W-1:0] >> {w_k, 5'b0});
  assign w_be = w_cap ? 4'hF : req_size == SZ_B ? 4'b0001 << w_off : req_size == SZ_H ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'hF;
  assign w_sdata = req_size == SZ_B ? {4{req_wdata[7:0]}} : req_size == SZ_H ? {2{req_wdata[15:0]}} : req_wdata[31:0];
  assign w_wword = w_cap ? w_cap_word : w_sdata;
  assign w_rword = r_mem[w_idx];
  assign w_byte = 8'(w_rword >> {w_off, 3'b0});
  assign w_half = w_off[1] ? w_rword[31:16] : w_rword[15:0];
  assign w_lval = req_size == SZ_B ? {{24{req_signed & w_byte[7]}}, w_byte} : req_size == SZ_H ? {{16{req_signed & w_half[15]}}, w_half} : w_rword;
  assign w_rsp = (!w_beat_v || w_we) ? '0 : !w_cap ? DW'(w_lval) : w_final ? {w_tag, w_rword, r_acc} : '0;
  // Any store clears the granule tag on its first beat; only the last capability beat may set it.
  cap_tag_ram #(.N(DEPTH_WORDS / CAP_WORDS), .IW(AW - CL)) u_tags (
    .clk(clk),
    .rst(rst),
    .i_we(w_beat_v && w_we && (w_k == '0 || w_final)),
    .i_widx(w_idx[AW-1:CL]),
    .i_wval(w_final && w_wd[CAP_W]),
    .i_ridx(w_idx[AW-1:CL]),
    .o_rtag(w_tag)
  );
  always_ff @(posedge clk)
    if (w_beat_v && w_we)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat <= '0;
      r_idx <= '0;
      r_we <= 1'b0;
      r_wdata <= '0;
      r_acc <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= w_err || (w_beat_v && (!w_cap || w_final));
      rsp_err <= w_err;
      rsp_rdata <= w_rsp;
      if (w_beat_v && w_cap) r_acc <= (w_k == '0 ? '0 : r_acc) | (ACC_W'(w_rword) << {w_k, 5'b0});
      if (w_go && w_cap) begin
        r_state <= ST_BUSY;
        r_beat <= CL'(1);
        r_idx <= req_addr[AW+1:2];
        r_we <= req_we;
        r_wdata <= req_wdata;
      end else if (w_busy) begin
        r_state <= w_final ? ST_IDLE : ST_BUSY;
        r_beat <= w_final ? '0 : r_beat + 1'b1;
      end
    end
endmodule

// File: tb/tb_cap_data_memory.sv
// tb_cap_data_memory: directed-vector self-checking bench for cap_data_memory
module tb_cap_data_memory;
  import cap_mem_pkg::*;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0;
  logic [128:0] req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [128:0] rsp_rdata;
  int n_vec = 0, n_err = 0;
  logic [128:0] g_rd;
  logic g_err;
  int g_lat;
  logic [7:0] g_rdy;
  logic [128:0] cap_a, cap_b;
  logic [6:0] vv, rr;
  logic [128:0] d5;
  logic seen;
  logic [31:0] a4 [4];
  logic [31:0] e4 [4];
  logic [3:0] vq;

  always #5 clk = ~clk;

  cap_data_memory #(.DEPTH_WORDS(256), .CAP_W(128)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [128:0] wd);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    g_lat = 0; g_rd = '0; g_err = 0; g_rdy = '0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      g_rdy[c] = req_ready;
      if (rsp_valid && g_lat == 0) begin
        g_lat = c; g_rd = rsp_rdata; g_err = rsp_err;
      end
      @(posedge clk); #1;
      if (g_lat != 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    cap_a = {1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF};
    cap_b = {1'b0, 128'h00112233_44556677_8899ABCD_CCDDEEFF};
    #3;
    chk("rst_ready", 129'(req_ready), 129'd0);
    chk("rst_valid", 129'(rsp_valid), 129'd0);
    chk("rst_rdata", rsp_rdata, 129'd0);
    chk("rst_err", 129'(rsp_err), 129'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", 129'(req_ready), 129'd1);
    @(posedge clk); #1;
    xfer(1, SZ_W, 0, 32'h0, 129'h12345678);
    xfer(1, SZ_W, 0, 32'h10, 129'hDEADBEEF);
    chk("sw_lat", 129'(g_lat), 129'd1);
    chk("sw_err", 129'(g_err), 129'd0);
    chk("sw_rdata", g_rd, 129'd0);
    xfer(0, SZ_W, 0, 32'h10, 129'd0);
    chk("lw_lat", 129'(g_lat), 129'd1);
    chk("lw_rdata", g_rd, 129'hDEADBEEF);
    chk("lw_err", 129'(g_err), 129'd0);
    xfer(1, SZ_B, 0, 32'h13, 129'h80);
    chk("sb_err", 129'(g_err), 129'd0);
    xfer(0, SZ_B, 1, 32'h13, 129'd0);
    chk("lb_signed", g_rd, 129'hFFFFFF80);
    xfer(0, SZ_B, 0, 32'h13, 129'd0);
    chk("lbu", g_rd, 129'h80);
    xfer(0, SZ_W, 0, 32'h10, 129'd0);
    chk("lw_after_sb", g_rd, 129'h80ADBEEF);
    xfer(1, SZ_CAP, 0, 32'h20, cap_a);
    chk("csc_lat", 129'(g_lat), 129'd4);
    chk("csc_ready", 129'(g_rdy[4:1]), 129'b1000);
    chk("csc_err", 129'(g_err), 129'd0);
    xfer(0, SZ_CAP, 0, 32'h20, 129'd0);
    chk("clc_lat", 129'(g_lat), 129'd4);
    chk("clc_data_tag", g_rd, cap_a);
    xfer(1, SZ_H, 0, 32'h24, 129'hABCD);
    chk("sh_err", 129'(g_err), 129'd0);
    xfer(0, SZ_CAP, 0, 32'h20, 129'd0);
    chk("clc_after_sh", g_rd, cap_b);
    xfer(0, SZ_CAP, 0, 32'h28, 129'd0);
    chk("clc_misalign_err", 129'(g_err), 129'd1);
    chk("clc_misalign_lat", 129'(g_lat), 129'd1);
    chk("clc_misalign_rdata", g_rd, 129'd0);
    xfer(1, SZ_W, 0, 32'h400, 129'hFFFFFFFF);
    chk("sw_oor_err", 129'(g_err), 129'd1);
    chk("sw_oor_lat", 129'(g_lat), 129'd1);
    xfer(0, SZ_W, 0, 32'h0, 129'd0);
    chk("word0_kept", g_rd, 129'h12345678);
    xfer(0, SZ_H, 0, 32'h11, 129'd0);
    chk("lh_misalign_err", 129'(g_err), 129'd1);
    req_we = 1; req_size = SZ_CAP; req_signed = 0; req_addr = 32'h30;
    req_wdata = {1'b1, 128'h01020304_05060708_090A0B0C_0D0E0F10}; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    seen = 0;
    @(negedge clk);
    seen |= rsp_valid;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rst_busy_ready", 129'(req_ready), 129'd0);
    seen |= rsp_valid;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_busy_release_ready", 129'(req_ready), 129'd1);
    seen |= rsp_valid;
    repeat (5) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("rst_busy_no_rsp", 129'(seen), 129'd0);
    @(posedge clk); #1;
    xfer(0, SZ_CAP, 0, 32'h30, 129'd0);
    chk("rst_busy_tag", 129'(g_rd[128]), 129'd0);
    chk("rst_busy_beats", 129'(g_rd[63:0]), 129'h090A0B0C_0D0E0F10);
    req_we = 1; req_size = SZ_CAP; req_addr = 32'h40;
    req_wdata = {1'b0, 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'h0BADF00D}; req_valid = 1;
    @(posedge clk); #1;
    req_we = 0; req_size = SZ_W; req_wdata = 0;
    vv = '0; rr = '0; d5 = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vv[c] = rsp_valid;
      rr[c] = req_ready;
      if (c == 5) d5 = rsp_rdata;
      @(posedge clk); #1;
      if (c == 4) req_valid = 0;
    end
    chk("b2b_valid_pattern", 129'(vv[6:1]), 129'b011000);
    chk("b2b_ready_pattern", 129'(rr[4:1]), 129'b1000);
    chk("b2b_load_data", d5, 129'h0BADF00D);
    a4 = '{32'h10, 32'h20, 32'h24, 32'h0};
    e4 = '{32'h80ADBEEF, 32'hCCDDEEFF, 32'h8899ABCD, 32'h12345678};
    vq = '0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        req_we = 0; req_size = SZ_W; req_signed = 0; req_addr = a4[i]; req_valid = 1;
      end else req_valid = 0;
      @(negedge clk);
      if (i > 0) begin
        vq[i-1] = rsp_valid;
        chk($sformatf("stream_data%0d", i - 1), rsp_rdata, 129'(e4[i-1]));
      end
      @(posedge clk); #1;
    end
    chk("stream_valid", 129'(vq), 129'hF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
